// File: rtl/scr1_accel_pkg.sv
// scr1_accel_pkg: shared sizes, engine state type and result saturation for the neuron engine
package scr1_accel_pkg;
  localparam int N_NEURONS     = 10;
  localparam int N_PIXELS      = 49;
  localparam int PIX_PER_CHUNK = 10;
  localparam int W_BIAS        = 32;
  localparam int W_WEIGHT      = 32;
  localparam int W_PIXEL       = 32;
  localparam int W_RESULT      = 32;
  localparam int W_ACC         = 64;
  localparam int FRAC_BITS     = 0;
  localparam int N_CHUNKS      = (N_PIXELS + PIX_PER_CHUNK - 1) / PIX_PER_CHUNK;
  localparam int LAST_LEN      = N_PIXELS - (N_CHUNKS - 1) * PIX_PER_CHUNK;
  localparam int CNT_W         = $clog2(PIX_PER_CHUNK + 1);
  localparam int CHUNK_W       = $clog2(N_CHUNKS + 1);
  localparam logic signed [W_ACC-1:0] RES_MAX = {{(W_ACC-W_RESULT+1){1'b0}}, {(W_RESULT-1){1'b1}}};
  localparam logic signed [W_ACC-1:0] RES_MIN = ~RES_MAX;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_MAC,
    ST_FINISH,
    ST_DONE
  } type_scr1_accel_eng_state_e;
  // Scale the accumulator down by FRAC_BITS and clamp it into the signed result range
  function automatic logic [W_RESULT-1:0] sat_result(input logic signed [W_ACC-1:0] acc);
    logic signed [W_ACC-1:0] y;
    y = acc >>> FRAC_BITS;
    return (y > RES_MAX) ? RES_MAX[W_RESULT-1:0] : (y < RES_MIN) ? RES_MIN[W_RESULT-1:0] : y[W_RESULT-1:0];
  endfunction
endpackage

// File: rtl/scr1_accel_mac_lane.sv
// scr1_accel_mac_lane: one neuron's accumulator with bias load, signed MAC and saturated result register
module scr1_accel_mac_lane
  import scr1_accel_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init,
  input  logic                       acc_en,
  input  logic                       finish,
  input  logic signed [W_BIAS-1:0]   bias,
  input  logic signed [W_PIXEL-1:0]  pixel,
  input  logic signed [W_WEIGHT-1:0] weight,
  output logic [W_RESULT-1:0]        result
);
  logic signed [W_ACC-1:0] acc;
  logic signed [W_ACC-1:0] prod;
  assign prod = W_ACC'(pixel) * W_ACC'(weight);
  // Layer start reloads the bias; otherwise accumulate products, and latch the clamped sum on finish
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      result <= '0;
    end else if (init) begin
      acc <= W_ACC'(bias);
    end else if (acc_en) begin
      acc <= acc + prod;
    end else if (finish) begin
      result <= sat_result(acc);
    end
  end
endmodule

// File: rtl/scr1_accel_neuron_engine.sv
// scr1_accel_neuron_engine: dense-layer engine fed chunk by chunk from the accelerator register file
module scr1_accel_neuron_engine
  import scr1_accel_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    new_layer,
  input  logic                                    pixel_ready,
  input  logic [PIX_PER_CHUNK*W_PIXEL-1:0]        pixel_regs,
  input  logic [N_NEURONS*W_BIAS-1:0]             bias_regs,
  input  logic [N_NEURONS*N_PIXELS*W_WEIGHT-1:0]  weight_regs,
  output logic [N_NEURONS*W_RESULT-1:0]           neurons_result_regs,
  output logic                                    layer_done,
  output logic                                    busy,
  output logic                                    overrun
);
  type_scr1_accel_eng_state_e state;
  logic [CHUNK_W-1:0] chunk_idx;
  logic [CNT_W-1:0]   strobe_cnt;
  logic [CNT_W-1:0]   pix_k;
  logic [CNT_W-1:0]   target;
  logic [W_PIXEL-1:0] snap [PIX_PER_CHUNK];
  logic [W_RESULT-1:0] res [N_NEURONS];
  logic last_chunk;
  logic counting;
  logic chunk_hit;
  logic mac_end;
  logic acc_en;
  logic fin;
  int   pix_idx;
  assign last_chunk = chunk_idx == CHUNK_W'(N_CHUNKS - 1);
  assign target     = last_chunk ? CNT_W'(LAST_LEN) : CNT_W'(PIX_PER_CHUNK);
  assign counting   = state == ST_COLLECT || state == ST_MAC;
  assign chunk_hit  = counting && pixel_ready && !new_layer && strobe_cnt == target - 1'b1;
  assign mac_end    = state == ST_MAC && pix_k == target - 1'b1;
  assign acc_en     = state == ST_MAC && !new_layer;
  assign fin        = state == ST_FINISH && !new_layer;
  assign pix_idx    = int'(chunk_idx) * PIX_PER_CHUNK + int'(pix_k);
  assign busy       = state == ST_COLLECT || state == ST_MAC || state == ST_FINISH;
  assign layer_done = state == ST_DONE;
  // Sequencing: strobe counting, chunk capture, per-pixel MAC stepping and layer completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      chunk_idx  <= '0;
      strobe_cnt <= '0;
      pix_k      <= '0;
      overrun    <= 1'b0;
      snap       <= '{default: '0};
    end else if (new_layer) begin
      state      <= ST_COLLECT;
      chunk_idx  <= '0;
      strobe_cnt <= '0;
      pix_k      <= '0;
      overrun    <= 1'b0;
    end else begin
      if (counting && pixel_ready) strobe_cnt <= chunk_hit ? '0 : strobe_cnt + 1'b1;
      if (chunk_hit && state == ST_MAC) overrun <= 1'b1;
      if (chunk_hit && state == ST_COLLECT) begin
        for (int k = 0; k < PIX_PER_CHUNK; k++) snap[k] <= pixel_regs[k*W_PIXEL +: W_PIXEL];
        state <= ST_MAC;
      end
      if (state == ST_MAC) begin
        pix_k <= mac_end ? '0 : pix_k + 1'b1;
        if (mac_end) begin
          chunk_idx <= chunk_idx + 1'b1;
          state     <= last_chunk ? ST_FINISH : ST_COLLECT;
        end
      end
      if (state == ST_FINISH) state <= ST_DONE;
    end
  end
  for (genvar n = 0; n < N_NEURONS; n++) begin : g_lane
    scr1_accel_mac_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .init   (new_layer),
      .acc_en (acc_en),
      .finish (fin),
      .bias   (bias_regs[n*W_BIAS +: W_BIAS]),
      .pixel  (snap[pix_k]),
      .weight (weight_regs[(n*N_PIXELS + pix_idx)*W_WEIGHT +: W_WEIGHT]),
      .result (res[n])
    );
  end
  // Flatten lane results onto the read-back bus
  always_comb begin
    neurons_result_regs = '0;
    for (int n = 0; n < N_NEURONS; n++) neurons_result_regs[n*W_RESULT +: W_RESULT] = res[n];
  end
endmodule

// File: tb/tb_scr1_accel_neuron_engine.sv
// tb_scr1_accel_neuron_engine: scoreboard bench for the neuron engine
module tb_scr1_accel_neuron_engine;
  localparam int NN = 10;
  localparam int NP = 49;
  localparam int PC = 10;
  localparam int NC = 5;
  localparam int LL = 9;
  logic clk = 1'b0;
  logic rst;
  logic new_layer;
  logic pixel_ready;
  logic [PC*32-1:0] pixel_regs;
  logic [NN*32-1:0] bias_regs;
  logic [NN*NP*32-1:0] weight_regs;
  logic [NN*32-1:0] neurons_result_regs;
  logic layer_done;
  logic busy;
  logic overrun;
  int bias [NN];
  int wt [NN][NP];
  int pix [NP];
  logic [31:0] last_res [NN];
  logic [31:0] exp_q [$];
  logic exp_ovr = 1'b0;
  int checks = 0;
  int failures = 0;
  scr1_accel_neuron_engine dut (
    .clk                 (clk),
    .rst                 (rst),
    .new_layer           (new_layer),
    .pixel_ready         (pixel_ready),
    .pixel_regs          (pixel_regs),
    .bias_regs           (bias_regs),
    .weight_regs         (weight_regs),
    .neurons_result_regs (neurons_result_regs),
    .layer_done          (layer_done),
    .busy                (busy),
    .overrun             (overrun)
  );
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  task automatic push_expected();
    for (int n = 0; n < NN; n++) begin
      longint acc = longint'(bias[n]);
      for (int p = 0; p < NP; p++) acc += longint'(pix[p]) * longint'(wt[n][p]);
      if (acc > 64'sh7FFF_FFFF) exp_q.push_back(32'h7FFF_FFFF);
      else if (acc < -64'sh8000_0000) exp_q.push_back(32'h8000_0000);
      else exp_q.push_back(acc[31:0]);
    end
  endtask
  task automatic load();
    for (int n = 0; n < NN; n++) begin
      bias_regs[n*32 +: 32] = bias[n];
      for (int p = 0; p < NP; p++) weight_regs[(n*NP+p)*32 +: 32] = wt[n][p];
    end
  endtask
  task automatic start_layer(input bit nl_strobe);
    load();
    new_layer = 1'b1;
    pixel_ready = nl_strobe;
    tick();
    new_layer = 1'b0;
    pixel_ready = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_done", {31'd0, layer_done}, 32'd0);
    chk("start_ovr", {31'd0, overrun}, 32'd0);
    chk("held_res0", neurons_result_regs[31:0], last_res[0]);
  endtask
  task automatic set_chunk(input int c);
    int len = (c == NC-1) ? LL : PC;
    for (int k = 0; k < PC; k++) pixel_regs[k*32 +: 32] = (k < len) ? pix[c*PC+k] : 32'h5A5A_5A5A;
  endtask
  task automatic send_chunk(input int c);
    int len = (c == NC-1) ? LL : PC;
    set_chunk(c);
    for (int i = 0; i < len; i++) begin
      pixel_ready = 1'b1;
      tick();
      pixel_ready = 1'b0;
      if (i < len-1) tick();
    end
  endtask
  task automatic finish_layer();
    int lat = 0;
    while (!layer_done && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", lat, LL+1);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_ovr", {31'd0, overrun}, {31'd0, exp_ovr});
    for (int n = 0; n < NN; n++) begin
      logic [31:0] r;
      if (exp_q.size() == 0) begin
        chk("queue_empty", 32'd0, 32'd1);
        break;
      end
      r = exp_q.pop_front();
      chk($sformatf("res%0d", n), neurons_result_regs[n*32 +: 32], r);
      last_res[n] = r;
    end
  endtask
  task automatic run_layer(input bit nl_strobe);
    push_expected();
    start_layer(nl_strobe);
    for (int c = 0; c < NC; c++) begin
      send_chunk(c);
      if (c < NC-1) repeat (PC+1) tick();
    end
    finish_layer();
  endtask
  task automatic rand_data();
    for (int n = 0; n < NN; n++) begin
      bias[n] = int'($urandom_range(0, 20000)) - 10000;
      for (int p = 0; p < NP; p++) wt[n][p] = int'($urandom_range(0, 2000)) - 1000;
    end
    for (int p = 0; p < NP; p++) pix[p] = int'($urandom_range(0, 2000)) - 1000;
  endtask
  initial begin
    rst = 1'b1;
    new_layer = 1'b0;
    pixel_ready = 1'b0;
    pixel_regs = '0;
    bias_regs = '0;
    weight_regs = '0;
    for (int n = 0; n < NN; n++) last_res[n] = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, layer_done}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    for (int n = 0; n < NN; n++) chk($sformatf("rst_res%0d", n), neurons_result_regs[n*32 +: 32], 32'd0);
    pixel_ready = 1'b1;
    repeat (12) tick();
    pixel_ready = 1'b0;
    tick();
    chk("unarmed_busy", {31'd0, busy}, 32'd0);
    chk("unarmed_done", {31'd0, layer_done}, 32'd0);
    chk("unarmed_ovr", {31'd0, overrun}, 32'd0);
    for (int n = 0; n < NN; n++) begin
      bias[n] = n;
      for (int p = 0; p < NP; p++) wt[n][p] = int'($urandom);
    end
    for (int p = 0; p < NP; p++) pix[p] = 0;
    run_layer(1'b0);
    for (int n = 0; n < NN; n++) begin
      bias[n] = 0;
      for (int p = 0; p < NP; p++) wt[n][p] = n + 1;
    end
    for (int p = 0; p < NP; p++) pix[p] = 1;
    run_layer(1'b1);
    for (int n = 0; n < NN; n++) begin
      bias[n] = (n == 0) ? 5 : n;
      for (int p = 0; p < NP; p++) wt[n][p] = (n == 0) ? 7 : n - 4;
    end
    for (int p = 0; p < NP; p++) pix[p] = -3;
    run_layer(1'b0);
    chk("mixed_sign_res0", last_res[0], 32'hFFFF_FC00);
    for (int n = 0; n < NN; n++) begin
      bias[n] = 0;
      for (int p = 0; p < NP; p++) wt[n][p] = 32'h7FFF_FFFF;
    end
    for (int p = 0; p < NP; p++) pix[p] = 32'h7FFF_FFFF;
    run_layer(1'b0);
    chk("sat_pos", last_res[3], 32'h7FFF_FFFF);
    for (int p = 0; p < NP; p++) pix[p] = -32'sh7FFF_FFFF;
    run_layer(1'b0);
    chk("sat_neg", last_res[3], 32'h8000_0000);
    rand_data();
    push_expected();
    start_layer(1'b0);
    set_chunk(0);
    pixel_ready = 1'b1;
    repeat (PC) tick();
    for (int k = 0; k < PC; k++) pixel_regs[k*32 +: 32] = 32'h0123_4567 + k;
    repeat (PC) tick();
    pixel_ready = 1'b0;
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    chk("ovr_busy", {31'd0, busy}, 32'd1);
    repeat (2) tick();
    for (int c = 1; c < NC; c++) begin
      send_chunk(c);
      if (c < NC-1) repeat (PC+1) tick();
    end
    exp_ovr = 1'b1;
    finish_layer();
    exp_ovr = 1'b0;
    rand_data();
    start_layer(1'b0);
    for (int c = 0; c < 3; c++) begin
      send_chunk(c);
      if (c < 2) repeat (PC+1) tick();
    end
    repeat (3) tick();
    chk("abort_busy", {31'd0, busy}, 32'd1);
    rand_data();
    run_layer(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
